// File: rtl/log_mult_accumulator.sv
// rtl/log_mult_accumulator.sv - frame accumulator for log-multiplier products; LOG_ACC_SATURATE_EN selects clamping
module log_mult_accumulator #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic                       out_ovf,
    output logic [$clog2(LEN+1)-1:0]   frame_cnt
);
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W:0]   sum;
    logic             ovf_next;
    logic [ACC_W-1:0] acc_next;

    always_comb begin
        sum      = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
        ovf_next = ovf | sum[ACC_W];
`ifdef LOG_ACC_SATURATE_EN
        // once the frame has overflowed the total stays pinned at full scale
        acc_next = ovf_next ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

    assign in_ready = (state == ACCUM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (frame_cnt == LAST) begin
                            out_data  <= acc_next;
                            out_ovf   <= ovf_next;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            ovf       <= 1'b0;
                            frame_cnt <= '0;
                            state     <= HOLD;
                        end else begin
                            acc       <= acc_next;
                            ovf       <= ovf_next;
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_log_mult_accumulator.sv
// tb/tb_log_mult_accumulator.sv - randomized scoreboard bench for log_mult_accumulator (three configurations)
module tb_log_mult_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]       in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [2:0][15:0] in_data;
    logic [2:0][23:0] od;
    logic [2:0][3:0]  fc;
    logic [23:0] od0, od2;
    logic [16:0] od1;
    logic [3:0]  fc0;
    logic [2:0]  fc1;
    logic [0:0]  fc2;

    assign od[0] = od0;
    assign od[1] = {7'd0, od1};
    assign od[2] = od2;
    assign fc[0] = fc0;
    assign fc[1] = {1'b0, fc1};
    assign fc[2] = {3'b000, fc2};

    log_mult_accumulator u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0),
        .out_ovf(out_ovf[0]), .frame_cnt(fc0));
    log_mult_accumulator #(.DATA_W(16), .ACC_W(17), .LEN(4)) u1 (.clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(od1), .out_ovf(out_ovf[1]), .frame_cnt(fc1));
    log_mult_accumulator #(.DATA_W(16), .ACC_W(24), .LEN(1)) u2 (.clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(od2), .out_ovf(out_ovf[2]), .frame_cnt(fc2));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [24:0] sb [3][$];
    longint tot [3];
    int     cnt [3];
    int     fin_cyc [3];
    bit     held [3];
    bit     after_hs [3];
    logic [24:0] hd [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int accw(int k);
        return (k == 1) ? 17 : 24;
    endfunction

    function automatic int flen(int k);
        return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
    endfunction

    // expected frame result from the plain integer sum of its products
    function automatic logic [24:0] model(int k, longint t);
        longint m  = longint'(1) << accw(k);
        logic   ov = (t >= m);
        longint d  = t % m;
`ifdef LOG_ACC_SATURATE_EN
        if (ov) d = m - 1;
`endif
        return {ov, d[23:0]};
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int k, input logic [15:0] v);
        int w = 0;
        while (!in_ready[k] && w < 50) begin
            tick(1);
            w++;
        end
        if (!in_ready[k]) begin
            check(1'b0, "ready_timeout", 0, 1);
            return;
        end
        check(fc[k] == 4'(cnt[k]), "frame_cnt", fc[k], cnt[k]);
        in_valid[k] = 1'b1;
        in_data[k]  = v;
        tick(1);
        in_valid[k] = 1'b0;
        tot[k] += longint'(v);
        cnt[k]++;
        if (cnt[k] == flen(k)) begin
            sb[k].push_back(model(k, tot[k]));
            cnt[k] = 0;
            tot[k] = 0;
            fin_cyc[k] = cyc;
            check(out_valid[k] == 1'b1, "out_valid_latency", out_valid[k], 1);
            check(in_ready[k] == 1'b0, "in_ready_low_hold", in_ready[k], 0);
        end
    endtask

    task automatic do_reset(input int k);
        rst_n = 1'b0;
        tick(1);
        for (int j = 0; j < 3; j++) begin
            check(out_valid[j] == 1'b0, "rst_out_valid", out_valid[j], 0);
            check(in_ready[j] == 1'b1, "rst_in_ready", in_ready[j], 1);
            check(od[j] == 24'd0 && out_ovf[j] == 1'b0, "rst_out_data", od[j], 0);
            check(fc[j] == 4'd0, "rst_frame_cnt", fc[j], 0);
        end
        sb[k].delete();
        cnt[k] = 0;
        tot[k] = 0;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                held[k]     = 1'b0;
                after_hs[k] = 1'b0;
            end else begin
                if (after_hs[k]) check(!out_valid[k], "pulse_width", out_valid[k], 0);
                after_hs[k] = 1'b0;
                if (out_valid[k]) begin
                    check(!in_ready[k], "in_ready_in_hold", in_ready[k], 0);
                    if (held[k]) check({out_ovf[k], od[k]} == hd[k], "hold_stable", {out_ovf[k], od[k]}, hd[k]);
                    if (out_ready[k]) begin
                        if (sb[k].size() == 0) begin
                            check(1'b0, "unexpected_frame", {out_ovf[k], od[k]}, 0);
                        end else begin
                            logic [24:0] e;
                            e = sb[k].pop_front();
                            check({out_ovf[k], od[k]} == e, "frame_total", {out_ovf[k], od[k]}, e);
                        end
                        held[k]     = 1'b0;
                        after_hs[k] = 1'b1;
                    end else begin
                        held[k] = 1'b1;
                        hd[k]   = {out_ovf[k], od[k]};
                    end
                end else begin
                    held[k] = 1'b0;
                end
            end
        end
    end

    initial begin
        int p;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            tot[k] = 0;
            fin_cyc[k] = 0;
        end
        tick(2);
        do_reset(0);
        tick(1);

        // frame 1..8 back to back
        for (int i = 1; i <= 8; i++) send(0, 16'(i));
        tick(2);

        // gapped frame, then a long stall with in_valid asserted
        out_ready[0] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send(0, 16'(i));
            if (i < 8) tick(1);
        end
        in_valid[0] = 1'b1;
        in_data[0]  = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            check(in_ready[0] == 1'b0, "stall_in_ready", in_ready[0], 0);
            check(od[0] == 24'd36, "stall_out_data", od[0], 36);
            check(fc[0] == 4'd0, "stall_frame_cnt", fc[0], 0);
            tick(1);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick(1);
        for (int i = 1; i <= 8; i++) send(0, 16'(i));
        tick(2);

        // overflow on narrow accumulator
        for (int i = 0; i < 4; i++) send(1, 16'hFFFF);
        tick(2);

        // reset mid-frame, then a clean frame
        for (int i = 0; i < 5; i++) send(0, 16'h0100 + 16'(i));
        do_reset(0);
        for (int i = 0; i < 8; i++) send(0, 16'h0100);
        tick(2);

        // reset while a total is held
        out_ready[0] = 1'b0;
        for (int i = 0; i < 8; i++) send(0, 16'h7777);
        tick(3);
        do_reset(0);
        out_ready[0] = 1'b1;
        tick(2);

        // LEN=1 frames
        send(2, 16'h1234);
        tick(1);
        check(in_ready[2] == 1'b1, "len1_ready_back", in_ready[2], 1);
        send(2, 16'hABCD);
        tick(2);

        // back-to-back random frames with period check
        p = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) send(0, 16'($urandom_range(0, 65535)));
            if (f > 0) check(fin_cyc[0] - p == 9, "frame_period", fin_cyc[0] - p, 9);
            p = fin_cyc[0];
        end
        tick(2);

        // random frames with random stalls on the narrow configuration
        for (int f = 0; f < 8; f++) begin
            out_ready[1] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                send(1, (f % 2 == 0) ? 16'($urandom_range(49152, 65535)) : 16'($urandom_range(0, 65535)));
                if ($urandom_range(0, 2) == 0) tick(1);
            end
            tick($urandom_range(0, 3));
            out_ready[1] = 1'b1;
            tick(1);
        end
        tick(4);

        for (int k = 0; k < 3; k++) check(sb[k].size() == 0, "drain", sb[k].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
